cam_sequencer: RTL

Command sequencer that sits directly upstream of the `cam` array and drives its control pins. It accepts one high-level command at a time: search, select-first, write or read. It expands each command into the set / perform_search / select_first / write_lines pulse sequence the array requires, then returns the resulting tag vector and read data on a response channel. Software-facing logic never drives the CAM pins directly.

---
 rtl/cam_pkg.sv | 52 +++++
 rtl/phase_timer.sv | 35 +++
 rtl/cam_sequencer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/cam_pkg.sv
// Shared types and helpers for the CAM command sequencer: op and FSM encodings,
// write-line encoding and popcount sized for the widest supported array.
package cam_pkg;

  localparam int CAM_MAX_BITS  = 32;
  localparam int CAM_MAX_CELLS = 64;

  typedef enum logic [1:0] {
    OP_SEARCH       = 2'd0,
    OP_SELECT_FIRST = 2'd1,
    OP_WRITE        = 2'd2,
    OP_READ         = 2'd3
  } cam_op_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SET_HI,
    ST_SET_LO,
    ST_SRCH_HI,
    ST_SRCH_LO,
    ST_SEL_HI,
    ST_SEL_LO,
    ST_WR_HI,
    ST_WR_LO,
    ST_CAPTURE,
    ST_RESP
  } cam_state_e;

  // Each masked bit drives one line of its pair: even line writes a 1, odd line writes a 0.
  function automatic logic [2*CAM_MAX_BITS-1:0] write_lines_enc(
    input logic [CAM_MAX_BITS-1:0] data,
    input logic [CAM_MAX_BITS-1:0] mask
  );
    logic [2*CAM_MAX_BITS-1:0] r;
    r = '0;
    for (int i = 0; i < CAM_MAX_BITS; i++) begin
      r[2*i]   = data[i] & mask[i];
      r[2*i+1] = ~data[i] & mask[i];
    end
    return r;
  endfunction

  function automatic logic [6:0] popcount(input logic [CAM_MAX_CELLS-1:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < CAM_MAX_CELLS; i++) begin
      c = c + 7'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter timing each FSM phase; done_o is high once the count reaches 0.
// A load of N-1 on state entry yields a phase exactly N cycles long.
module phase_timer #(
  parameter int MAX_CYCLES = 100,
  localparam int W = $clog2(MAX_CYCLES + 1)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/cam_sequencer.sv
// Expands one SEARCH / SELECT_FIRST / WRITE / READ command into CAM pin pulses and
// returns captured tags, popcount and read data on a valid/ready response channel.
module cam_sequencer
  import cam_pkg::*;
#(
  parameter int NUM_BITS     = 2,
  parameter int NUM_CELLS    = 10,
  parameter int PHASE_CYCLES = 10,
  parameter int SEL_CYCLES   = 2,
  parameter int WR_CYCLES    = 10,
  parameter int WR_SETTLE    = 100,
  localparam int CW = $clog2(NUM_CELLS + 1)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [NUM_BITS-1:0]   cmd_data,
  input  logic [NUM_BITS-1:0]   cmd_mask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [NUM_CELLS-1:0]  rsp_tags,
  output logic [CW-1:0]         rsp_count,
  output logic [NUM_BITS-1:0]   rsp_data,
  output logic [NUM_BITS-1:0]   cam_comparand,
  output logic [NUM_BITS-1:0]   cam_mask,
  output logic                  cam_set,
  output logic                  cam_perform_search,
  output logic                  cam_select_first,
  output logic [2*NUM_BITS-1:0] cam_write_lines,
  input  logic [NUM_CELLS-1:0]  cam_tags,
  input  logic [NUM_BITS-1:0]   cam_read_lines
);

  localparam int MAX_A   = (PHASE_CYCLES > SEL_CYCLES) ? PHASE_CYCLES : SEL_CYCLES;
  localparam int MAX_B   = (WR_CYCLES > WR_SETTLE) ? WR_CYCLES : WR_SETTLE;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam int WLW     = 2 * NUM_BITS;

  localparam logic [TW-1:0] LD_PHASE  = TW'(PHASE_CYCLES - 1);
  localparam logic [TW-1:0] LD_SEL    = TW'(SEL_CYCLES - 1);
  localparam logic [TW-1:0] LD_WR     = TW'(WR_CYCLES - 1);
  localparam logic [TW-1:0] LD_SETTLE = TW'(WR_SETTLE - 1);

  cam_state_e             state_q, state_d;
  logic [NUM_BITS-1:0]    data_q, mask_q;
  logic [NUM_CELLS-1:0]   tags_q;
  logic [CW-1:0]          count_q;
  logic [NUM_BITS-1:0]    rdata_q;
  logic                   tmr_load;
  logic [TW-1:0]          tmr_val;
  logic                   tmr_done;
  logic                   accept;

  phase_timer #(.MAX_CYCLES(MAX_CYC)) u_timer (
    .clk_i      (CLK),
    .rst_ni     (RST_N),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  assign cmd_ready = (state_q == ST_IDLE);
  assign accept    = cmd_valid & cmd_ready;

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          tmr_load = 1'b1;
          unique case (cam_op_e'(cmd_op))
            OP_SEARCH:       begin state_d = ST_SET_HI; tmr_val = LD_PHASE; end
            OP_SELECT_FIRST: begin state_d = ST_SEL_HI; tmr_val = LD_SEL;   end
            OP_WRITE:        begin state_d = ST_WR_HI;  tmr_val = LD_WR;    end
            default:         begin state_d = ST_CAPTURE; tmr_load = 1'b0;   end
          endcase
        end
      end
      ST_SET_HI:  if (tmr_done) begin state_d = ST_SET_LO;  tmr_load = 1'b1; tmr_val = LD_PHASE;  end
      ST_SET_LO:  if (tmr_done) begin state_d = ST_SRCH_HI; tmr_load = 1'b1; tmr_val = LD_PHASE;  end
      ST_SRCH_HI: if (tmr_done) begin state_d = ST_SRCH_LO; tmr_load = 1'b1; tmr_val = LD_PHASE;  end
      ST_SEL_HI:  if (tmr_done) begin state_d = ST_SEL_LO;  tmr_load = 1'b1; tmr_val = LD_SEL;    end
      ST_WR_HI:   if (tmr_done) begin state_d = ST_WR_LO;   tmr_load = 1'b1; tmr_val = LD_SETTLE; end
      ST_SRCH_LO, ST_SEL_LO, ST_WR_LO: if (tmr_done) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_RESP;
      ST_RESP:    if (rsp_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      mask_q  <= '0;
      tags_q  <= '0;
      count_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q <= cmd_data;
        mask_q <= cmd_mask;
      end
      if (state_q == ST_CAPTURE) begin
        tags_q  <= cam_tags;
        count_q <= CW'(popcount(CAM_MAX_CELLS'(cam_tags)));
        rdata_q <= cam_read_lines;
      end
    end
  end

  assign cam_comparand      = data_q;
  assign cam_mask           = mask_q;
  assign cam_set            = (state_q == ST_SET_HI);
  assign cam_perform_search = (state_q == ST_SRCH_HI);
  assign cam_select_first   = (state_q == ST_SEL_HI);
  assign cam_write_lines    = (state_q == ST_WR_HI)
                              ? WLW'(write_lines_enc(CAM_MAX_BITS'(data_q), CAM_MAX_BITS'(mask_q)))
                              : '0;

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_tags  = tags_q;
  assign rsp_count = count_q;
  assign rsp_data  = rdata_q;

endmodule
